// File: rtl/ysyx_24080006_ifu.sv
// ============================================================================
// ysyx_24080006_ifu -- instruction fetch unit for the RV32E execute core
//
// Takes a fetch PC from the core, issues one read on the instruction-memory
// port (never more than one outstanding), and hands the instruction word,
// its PC and a fault flag back to the core over a valid/ready handshake.
// A flush abandons whatever fetch is in flight. If a request has already been
// accepted by memory, its response is drained and discarded before a new PC
// is taken.
//
// Parameters
//   TIMEOUT   cycles a fetch may spend waiting for a response before it is
//             reported as a fault (1..65535)
//   RESET_PC  value shown on inst_pc / mem_req_addr out of reset
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   flush            abandon the current fetch (branch / trap redirect)
//   pc_valid/ready   fetch PC handshake, pc_i is the address
//   mem_req_*        read request channel (valid/ready, word address)
//   mem_resp_*       read response: data plus access-fault flag. It has no
//                    ready because memory cannot be back-pressured.
//   inst_valid/ready instruction handshake towards the core
//   inst_o, inst_pc  instruction word and the PC it was fetched from
//   inst_err         fetch fault: misaligned PC, bus error or timeout
// ============================================================================
module ysyx_24080006_ifu #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic [31:0] pc_i,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc,
    output logic        inst_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    // Counter compare value, one bit wider than the counter so the
    // incremented count can be compared without wrapping.
    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg,  addr_next;
    logic [31:0] inst_reg,  inst_next;
    logic        err_reg,   err_next;
    logic [15:0] cnt_reg,   cnt_next;

    logic [16:0] cnt_plus1;
    logic        timeout_hit;
    logic        pc_accept;
    logic        pc_misaligned;

    // The counter holds the number of completed waiting cycles. The current
    // cycle is the last allowed one when the count including it reaches
    // TIMEOUT, so a fetch waits at most TIMEOUT cycles in WAIT.
    assign cnt_plus1     = {1'b0, cnt_reg} + 17'd1;
    assign timeout_hit   = (cnt_plus1 == TIMEOUT_W);
    assign pc_misaligned = (pc_i[1:0] != 2'b00);

    // A new PC can be taken from IDLE, or from HOLD in the same cycle the
    // core consumes the held instruction, so back-to-back fetches do not
    // need a bubble. Flush and reset always refuse it.
    assign pc_ready  = !rst && !flush &&
                       ((state_reg == ST_IDLE) ||
                        ((state_reg == ST_HOLD) && inst_ready));
    assign pc_accept = pc_valid && pc_ready;

    assign mem_req_valid = (state_reg == ST_REQ);
    assign mem_req_addr  = {addr_reg[31:2], 2'b00};
    assign inst_valid    = (state_reg == ST_HOLD);
    assign inst_o        = inst_reg;
    assign inst_pc       = addr_reg;
    assign inst_err      = err_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        inst_next  = inst_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;

        unique case (state_reg)
            ST_IDLE: begin
                // Only a PC accept moves us out of IDLE, handled below.
            end

            ST_REQ: begin
                if (flush) begin
                    // If memory takes the request in the same cycle, its
                    // response is still coming and must be drained.
                    // Otherwise the request is withdrawn.
                    state_next = mem_req_ready ? ST_DRAIN : ST_IDLE;
                    cnt_next   = '0;
                end else if (mem_req_ready) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end
            end

            ST_WAIT: begin
                if (flush) begin
                    // A coincident response retires the request, so nothing
                    // is left to drain.
                    state_next = mem_resp_valid ? ST_IDLE : ST_DRAIN;
                    cnt_next   = '0;
                end else if (mem_resp_valid) begin
                    state_next = ST_HOLD;
                    inst_next  = mem_resp_data;
                    err_next   = mem_resp_err;
                end else if (timeout_hit) begin
                    // Give up on this fetch. The memory model does not track
                    // outstanding requests, so a late response is simply
                    // ignored once we leave WAIT.
                    state_next = ST_HOLD;
                    inst_next  = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_plus1[15:0];
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (inst_ready) begin
                    // A PC offered in this cycle overrides this below.
                    state_next = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                if (flush) begin
                    // A repeated flush keeps us draining. The counter stops
                    // at its final value so the timeout still fires on the
                    // first cycle without a flush.
                    if (!timeout_hit) begin
                        cnt_next = cnt_plus1[15:0];
                    end
                end else if (mem_resp_valid || timeout_hit) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_plus1[15:0];
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // pc_accept can only be true in IDLE, or in HOLD with inst_ready and
        // no flush, so it may override the per-state decision above.
        if (pc_accept) begin
            addr_next = pc_i;
            if (pc_misaligned) begin
                state_next = ST_HOLD;
                inst_next  = '0;
                err_next   = 1'b1;
            end else begin
                state_next = ST_REQ;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= RESET_PC;
            inst_reg  <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            inst_reg  <= inst_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule
